neuron_memory: RTL and testbench

Responder end of the neuron memory bus: the storage that sits downstream of the bus arbiter and answers its read address, write address, write data and write enable signals. It holds neuron weights and activations in a parameterised window of the address space and returns registered read data with one-cycle latency. It zero-fills itself after reset and flags writes it has to reject. It also counts accepted writes so the external loader can confirm a complete weight upload.

---
 rtl/neural_net_pkg.sv | 28 ++
 rtl/neuron_memory_array.sv | 24 ++
 rtl/neuron_memory.sv | 139 +++++++++++++
 tb/tb_neuron_memory.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/neural_net_pkg.sv
// Shared types and helpers for the neuron memory responder.
package neural_net_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    localparam int WRITE_COUNT_WIDTH = 16;

    // One bit wider than any supported address bus, so base + depth never wraps.
    localparam int WIN_W = 33;

    typedef struct packed {
        logic             inRange;
        logic [WIN_W-1:0] offset;
    } window_t;

    function automatic window_t in_window(input logic [WIN_W-1:0] addr,
                                          input logic [WIN_W-1:0] base,
                                          input logic [WIN_W-1:0] depth);
        window_t r;
        r.inRange = (addr >= base) && (addr < (base + depth));
        r.offset  = addr - base;
        return r;
    endfunction

endpackage

// File: rtl/neuron_memory_array.sv
// Plain synchronous RAM: one write port, one registered read-first read port, no reset.
module neuron_memory_array #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 256,
    parameter int IDX_W  = 8
) (
    input  logic              clk_i,
    input  logic              wrEn_i,
    input  logic [IDX_W-1:0]  wrAddr_i,
    input  logic [DATA_W-1:0] wrData_i,
    input  logic [IDX_W-1:0]  rdAddr_i,
    output logic [DATA_W-1:0] rdData_o
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk_i) begin
        if (wrEn_i) begin
            mem[wrAddr_i] <= wrData_i;
        end
        rdData_o <= mem[rdAddr_i];
    end

endmodule

// File: rtl/neuron_memory.sv
// Neuron memory bus responder: zero-fill after reset, windowed read/write,
// write-first forwarding, sticky write error and saturating write counter.
module neuron_memory
    import neural_net_pkg::*;
#(
    parameter int                           DATA_BUS_WIDTH    = 8,
    parameter int                           ADDRESS_BUS_WIDTH = 16,
    parameter int                           MEMORY_DEPTH      = 256,
    parameter logic [ADDRESS_BUS_WIDTH-1:0] BASE_ADDRESS      = '0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [ADDRESS_BUS_WIDTH-1:0] neuron_read_address,
    input  logic [ADDRESS_BUS_WIDTH-1:0] neuron_write_address,
    input  logic [DATA_BUS_WIDTH-1:0]    neuron_write_data,
    input  logic                         neuron_write_enable,
    input  logic                         error_clear,
    output logic [DATA_BUS_WIDTH-1:0]    neuron_read_data,
    output logic                         read_in_range,
    output logic                         busy,
    output logic                         write_error,
    output logic [WRITE_COUNT_WIDTH-1:0] write_count
);

    localparam int IDX_W = $clog2(MEMORY_DEPTH);

    state_t                       state_q, state_d;
    logic [IDX_W-1:0]             fillIdx_q, fillIdx_d;
    logic                         writeError_q, writeError_d;
    logic [WRITE_COUNT_WIDTH-1:0] writeCount_q, writeCount_d;
    logic                         readInRange_q, readInRange_d;
    logic                         readValid_q, readValid_d;
    logic                         fwdHit_q, fwdHit_d;
    logic [DATA_BUS_WIDTH-1:0]    fwdData_q, fwdData_d;

    window_t                      rdWin, wrWin;
    logic [IDX_W-1:0]             rdIdx, wrIdx;
    logic                         accept, reject;
    logic                         ramWe;
    logic [IDX_W-1:0]             ramWAddr;
    logic [DATA_BUS_WIDTH-1:0]    ramWData;
    logic [DATA_BUS_WIDTH-1:0]    ramRData;
    logic                         unusedOffsetBits;

    assign rdWin = in_window(WIN_W'(neuron_read_address), WIN_W'(BASE_ADDRESS), WIN_W'(MEMORY_DEPTH));
    assign wrWin = in_window(WIN_W'(neuron_write_address), WIN_W'(BASE_ADDRESS), WIN_W'(MEMORY_DEPTH));
    assign rdIdx = rdWin.offset[IDX_W-1:0];
    assign wrIdx = wrWin.offset[IDX_W-1:0];
    assign unusedOffsetBits = ^{rdWin.offset[WIN_W-1:IDX_W], wrWin.offset[WIN_W-1:IDX_W]};

    assign accept = (state_q == ST_READY) && neuron_write_enable && wrWin.inRange;
    assign reject = neuron_write_enable && ((state_q == ST_CLEAR) || !wrWin.inRange);

    always_comb begin
        state_d       = state_q;
        fillIdx_d     = fillIdx_q;
        writeError_d  = writeError_q;
        writeCount_d  = writeCount_q;
        readInRange_d = rdWin.inRange;
        readValid_d   = (state_q == ST_READY) && rdWin.inRange;
        fwdHit_d      = accept && (wrIdx == rdIdx);
        fwdData_d     = neuron_write_data;
        ramWe         = accept;
        ramWAddr      = wrIdx;
        ramWData      = neuron_write_data;

        case (state_q)
            ST_CLEAR: begin
                ramWe     = 1'b1;
                ramWAddr  = fillIdx_q;
                ramWData  = '0;
                fillIdx_d = fillIdx_q + 1'b1;
                if (fillIdx_q == IDX_W'(MEMORY_DEPTH - 1)) begin
                    state_d = ST_READY;
                end
            end
            ST_READY: begin
                state_d = ST_READY;
            end
            default: begin
                state_d = ST_CLEAR;
            end
        endcase

        // A new rejected write beats a simultaneous clear request.
        if (reject) begin
            writeError_d = 1'b1;
        end else if (error_clear) begin
            writeError_d = 1'b0;
        end

        if (accept && (writeCount_q != '1)) begin
            writeCount_d = writeCount_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_CLEAR;
            fillIdx_q     <= '0;
            writeError_q  <= 1'b0;
            writeCount_q  <= '0;
            readInRange_q <= 1'b0;
            readValid_q   <= 1'b0;
            fwdHit_q      <= 1'b0;
            fwdData_q     <= '0;
        end else begin
            state_q       <= state_d;
            fillIdx_q     <= fillIdx_d;
            writeError_q  <= writeError_d;
            writeCount_q  <= writeCount_d;
            readInRange_q <= readInRange_d;
            readValid_q   <= readValid_d;
            fwdHit_q      <= fwdHit_d;
            fwdData_q     <= fwdData_d;
        end
    end

    neuron_memory_array #(
        .DATA_W (DATA_BUS_WIDTH),
        .DEPTH  (MEMORY_DEPTH),
        .IDX_W  (IDX_W)
    ) u_array (
        .clk_i    (clk),
        .wrEn_i   (ramWe),
        .wrAddr_i (ramWAddr),
        .wrData_i (ramWData),
        .rdAddr_i (rdIdx),
        .rdData_o (ramRData)
    );

    // The RAM reads old data on a same-index collision, so the registered write wins here.
    assign neuron_read_data = !readValid_q ? '0 : (fwdHit_q ? fwdData_q : ramRData);
    assign read_in_range    = readInRange_q;
    assign busy             = (state_q == ST_CLEAR);
    assign write_error      = writeError_q;
    assign write_count      = writeCount_q;

endmodule

// File: tb/tb_neuron_memory.sv
// Scoreboard bench for neuron_memory with a window based at 16'h0100,
// checked against an array-based reference model of the bus behaviour.
module tb_neuron_memory;

    localparam int          DW    = 8;
    localparam int          AW    = 16;
    localparam int          DEPTH = 256;
    localparam logic [15:0] BASE  = 16'h0100;

    logic          clk;
    logic          reset;
    logic [AW-1:0] readAddr;
    logic [AW-1:0] writeAddr;
    logic [DW-1:0] writeData;
    logic          writeEnable;
    logic          errorClear;
    logic [DW-1:0] readData;
    logic          readInRange;
    logic          busy;
    logic          writeError;
    logic [15:0]   writeCount;

    neuron_memory #(
        .DATA_BUS_WIDTH    (DW),
        .ADDRESS_BUS_WIDTH (AW),
        .MEMORY_DEPTH      (DEPTH),
        .BASE_ADDRESS      (BASE)
    ) dut (
        .clk                  (clk),
        .reset                (reset),
        .neuron_read_address  (readAddr),
        .neuron_write_address (writeAddr),
        .neuron_write_data    (writeData),
        .neuron_write_enable  (writeEnable),
        .error_clear          (errorClear),
        .neuron_read_data     (readData),
        .read_in_range        (readInRange),
        .busy                 (busy),
        .write_error          (writeError),
        .write_count          (writeCount)
    );

    typedef struct {
        logic [7:0]  rdData;
        logic        inRange;
        logic        busy;
        logic        err;
        logic [15:0] count;
    } expect_t;

    expect_t    sbQueue[$];
    logic [7:0] modelMem [DEPTH];
    int         fillLeft;
    int         modelCount;
    bit         modelErr;
    int         vectors;
    int         miscompares;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one bus cycle, advance the model to the following edge and queue its expected outputs.
    task automatic applyStimulus(input logic rst, input logic [15:0] ra, input logic [15:0] wa,
                                 input logic [7:0] wd, input logic we, input logic clr);
        expect_t e;
        int      rdOff;
        int      wrOff;
        bit      ready;
        bit      rdIn;
        bit      wrIn;
        bit      rej;
        reset       = rst;
        readAddr    = ra;
        writeAddr   = wa;
        writeData   = wd;
        writeEnable = we;
        errorClear  = clr;
        if (rst) begin
            fillLeft   = DEPTH;
            modelCount = 0;
            modelErr   = 1'b0;
            for (int i = 0; i < DEPTH; i++) modelMem[i] = 8'h00;
            e = '{8'h00, 1'b0, 1'b1, 1'b0, 16'h0000};
        end else begin
            ready = (fillLeft == 0);
            rdOff = int'(ra) - int'(BASE);
            wrOff = int'(wa) - int'(BASE);
            rdIn  = (rdOff >= 0) && (rdOff < DEPTH);
            wrIn  = (wrOff >= 0) && (wrOff < DEPTH);
            rej   = we && !(ready && wrIn);
            if (we && !rej) begin
                modelMem[wrOff] = wd;
                if (modelCount < 65535) modelCount++;
            end
            if (rej) modelErr = 1'b1;
            else if (clr) modelErr = 1'b0;
            if (!ready) fillLeft--;
            e.rdData = 8'h00;
            if (ready && rdIn) e.rdData = modelMem[rdOff];
            e.inRange = rdIn;
            e.busy    = (fillLeft != 0);
            e.err     = modelErr;
            e.count   = 16'(modelCount);
        end
        sbQueue.push_back(e);
        @(negedge clk);
    endtask

    function automatic logic [15:0] randomAddr();
        if ($urandom_range(0, 7) == 0) return 16'($urandom);
        return 16'(32'h00E0 + $urandom_range(0, 32'h0160));
    endfunction

    task automatic randomCycle(input bit allowWrites);
        applyStimulus(1'b0, randomAddr(), randomAddr(), 8'($urandom),
                      1'(allowWrites && ($urandom_range(0, 1) == 1)),
                      1'($urandom_range(0, 9) == 0));
    endtask

    task automatic checkOutput(input string name, input logic [15:0] got, input logic [15:0] exp);
        if (got !== exp) begin
            $display("[TB] FAIL %s at vector %0d: got %h expected %h", name, vectors, got, exp);
            miscompares++;
        end
    endtask

    // Monitor: the DUT presents a fresh result after every rising edge.
    initial begin
        expect_t e;
        forever begin
            @(posedge clk);
            #2;
            if (sbQueue.size() > 0) begin
                e = sbQueue.pop_front();
                vectors++;
                checkOutput("read_data", {8'h00, readData}, {8'h00, e.rdData});
                checkOutput("read_in_range", {15'h0, readInRange}, {15'h0, e.inRange});
                checkOutput("busy", {15'h0, busy}, {15'h0, e.busy});
                checkOutput("write_error", {15'h0, writeError}, {15'h0, e.err});
                checkOutput("write_count", writeCount, e.count);
            end
        end
    end

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        readAddr    = '0;
        writeAddr   = '0;
        writeData   = '0;
        writeEnable = 1'b0;
        errorClear  = 1'b0;
        @(negedge clk);

        repeat (3) applyStimulus(1'b1, 16'h0000, 16'h0000, 8'h00, 1'b0, 1'b0);

        // Writes during the fill, then clear racing a new bad write, then clear alone.
        applyStimulus(1'b0, 16'h0100, 16'h0110, 8'h11, 1'b1, 1'b0);
        applyStimulus(1'b0, 16'h0100, 16'h0000, 8'h22, 1'b1, 1'b1);
        applyStimulus(1'b0, 16'h0100, 16'h0000, 8'h00, 1'b0, 1'b1);
        repeat (260) randomCycle(1'b0);

        for (int i = 0; i < DEPTH; i++) applyStimulus(1'b0, 16'(BASE + i), 16'h0000, 8'h00, 1'b0, 1'b0);

        applyStimulus(1'b0, 16'h0000, 16'h0110, 8'hA5, 1'b1, 1'b0);
        applyStimulus(1'b0, 16'h0110, 16'h0000, 8'h00, 1'b0, 1'b0);
        applyStimulus(1'b0, 16'h0100, 16'h00FF, 8'h77, 1'b1, 1'b0);
        applyStimulus(1'b0, 16'h0200, 16'h0200, 8'h88, 1'b1, 1'b0);
        applyStimulus(1'b0, 16'h01FF, 16'h0000, 8'h00, 1'b0, 1'b1);
        applyStimulus(1'b0, 16'h0100, 16'h01FF, 8'h5A, 1'b1, 1'b0);
        applyStimulus(1'b0, 16'h01FF, 16'h0000, 8'h00, 1'b0, 1'b0);
        applyStimulus(1'b0, 16'h0120, 16'h0120, 8'h3C, 1'b1, 1'b0);
        applyStimulus(1'b0, 16'h0120, 16'h0120, 8'hC3, 1'b1, 1'b0);
        applyStimulus(1'b0, 16'h0120, 16'h0000, 8'h00, 1'b0, 1'b0);

        repeat (1500) randomCycle(1'b1);

        // Reset mid-fill, then again after accepted writes; memory must read back as zero.
        repeat (2) applyStimulus(1'b1, 16'h0000, 16'h0000, 8'h00, 1'b0, 1'b0);
        repeat (100) randomCycle(1'b1);
        applyStimulus(1'b1, 16'h0000, 16'h0000, 8'h00, 1'b0, 1'b0);
        repeat (300) randomCycle(1'b1);
        repeat (2) applyStimulus(1'b1, 16'h0000, 16'h0000, 8'h00, 1'b0, 1'b0);
        repeat (258) randomCycle(1'b0);
        for (int i = 0; i < DEPTH; i++) applyStimulus(1'b0, 16'(BASE + i), 16'h0000, 8'h00, 1'b0, 1'b0);

        for (int i = 0; i < 5 && sbQueue.size() != 0; i++) @(negedge clk);
        if (sbQueue.size() != 0) begin
            $display("[TB] FAIL drain: got %0d pending expected 0", sbQueue.size());
            miscompares++;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
